qos_scheduler: RTL

Parametrised QoS read scheduler for NUM_Q input buffers; second-generation replacement for the fixed 4-queue priority selector. Each cycle it inspects per-queue occupancy and issues a registered one-hot read grant. Grant selection order: starved queues, then urgent queues, then any non-empty queue. The grant is held until the downstream reader acknowledges it, and a per-queue aging counter guarantees no queue starves.

---
 rtl/qos_scheduler_if.sv | 23 ++
 rtl/qos_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/qos_scheduler_if.sv
// rtl/qos_scheduler_if.sv - occupancy/grant bundle between queue buffers, QoS scheduler and reader
interface qos_scheduler_if #(
    parameter int NUM_Q = 4,
    parameter int CNT_W = 3
);
    logic [NUM_Q*CNT_W-1:0] data_count;
    logic [NUM_Q*CNT_W-1:0] urg_thr;
    logic                   grant_ack;
    logic [NUM_Q-1:0]       read_from;
    logic                   grant_valid;
    logic [1:0]             grant_reason;
    logic [NUM_Q-1:0]       starve_flag;

    modport master (
        input  data_count, urg_thr, grant_ack,
        output read_from, grant_valid, grant_reason, starve_flag
    );

    modport slave (
        output data_count, urg_thr, grant_ack,
        input  read_from, grant_valid, grant_reason, starve_flag
    );
endinterface

// File: rtl/qos_scheduler.sv
// rtl/qos_scheduler.sv - QoS read scheduler: starved > urgent > fallback, held one-hot grant, per-queue aging
// Optional: define RR_FALLBACK_EN for a round-robin fallback tier (fixed lowest-index otherwise).
module qos_scheduler #(
    parameter int NUM_Q   = 4,
    parameter int CNT_W   = 3,
    parameter int AGE_W   = 4,
    parameter int AGE_MAX = 12
) (
    input  logic            clk,
    input  logic            rst,
    qos_scheduler_if.master bus
);
    localparam logic [AGE_W-1:0] AGE_SAT = '1;
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

    state_t           state;
    logic [AGE_W-1:0] age [NUM_Q];
    logic [CNT_W-1:0] cnt [NUM_Q];
    logic [CNT_W-1:0] thr [NUM_Q];
    logic [NUM_Q-1:0] nonempty;
    logic [NUM_Q-1:0] urgent;
    logic [NUM_Q-1:0] aged;
    logic [NUM_Q-1:0] starved;
    logic [NUM_Q-1:0] starve_vec;
    logic [NUM_Q-1:0] urg_vec;
    logic [NUM_Q-1:0] fb_vec;
    logic [NUM_Q-1:0] sel_vec;
    logic [1:0]       sel_reason;
    logic [NUM_Q-1:0] read_from_q;
    logic [1:0]       reason_q;
    logic             valid_q;
    logic             ack_hit;

    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            cnt[i]      = bus.data_count[i*CNT_W +: CNT_W];
            thr[i]      = bus.urg_thr[i*CNT_W +: CNT_W];
            nonempty[i] = (cnt[i] != '0);
            urgent[i]   = (thr[i] != '0) && (cnt[i] >= thr[i]);
            aged[i]     = (age[i] >= AGE_LIM);
        end
    end

    assign starved = aged & nonempty;
    assign ack_hit = (state == GRANT) && bus.grant_ack;

`ifdef RR_FALLBACK_EN
    localparam int IDX_W = $clog2(NUM_Q);
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] sel_idx;
`endif

    // Starved tier: lowest index wins; urgent tier: highest index wins.
    always_comb begin
        starve_vec = '0;
        urg_vec    = '0;
        fb_vec     = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (starved[i]) starve_vec = NUM_Q'(1) << i;
        end
        for (int i = 0; i < NUM_Q; i++) begin
            if (urgent[i]) urg_vec = NUM_Q'(1) << i;
        end
`ifdef RR_FALLBACK_EN
        for (int k = NUM_Q; k >= 1; k--) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_Q;
            if (nonempty[j[IDX_W-1:0]]) fb_vec = NUM_Q'(1) << j;
        end
`else
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (nonempty[i]) fb_vec = NUM_Q'(1) << i;
        end
`endif
        if (starve_vec != '0) begin
            sel_vec    = starve_vec;
            sel_reason = 2'b11;
        end else if (urg_vec != '0) begin
            sel_vec    = urg_vec;
            sel_reason = 2'b10;
        end else if (fb_vec != '0) begin
            sel_vec    = fb_vec;
            sel_reason = 2'b01;
        end else begin
            sel_vec    = '0;
            sel_reason = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            read_from_q <= '0;
            reason_q    <= 2'b00;
            valid_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (nonempty != '0) begin
                        read_from_q <= sel_vec;
                        reason_q    <= sel_reason;
                        valid_q     <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.grant_ack) begin
                        read_from_q <= '0;
                        reason_q    <= 2'b00;
                        valid_q     <= 1'b0;
                        state       <= SETTLE;
                    end
                end
                SETTLE: state <= IDLE;
                default: begin
                    read_from_q <= '0;
                    reason_q    <= 2'b00;
                    valid_q     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Granted queue holds its age until acked; waiting non-empty queues climb and saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_Q; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (!nonempty[i] || (ack_hit && read_from_q[i])) begin
                    age[i] <= '0;
                end else if (!read_from_q[i] && age[i] != AGE_SAT) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

`ifdef RR_FALLBACK_EN
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (sel_vec[i]) sel_idx = IDX_W'(i);
        end
    end

    // Reset value NUM_Q-1 makes the first fallback search start at queue 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= IDX_W'(NUM_Q - 1);
            grant_idx <= '0;
        end else begin
            if (state == IDLE && nonempty != '0) grant_idx <= sel_idx;
            if (ack_hit) rr_ptr <= grant_idx;
        end
    end
`endif

    assign bus.read_from    = read_from_q;
    assign bus.grant_valid  = valid_q;
    assign bus.grant_reason = reason_q;
    assign bus.starve_flag  = aged;

endmodule
